fsk_tx_scheduler: RTL and testbench
===================================

Name: fsk_tx_scheduler

Overview:
Round-robin scheduler that shares one FSK modulator between NREQ requesters.
- Grants one requester at a time and captures its WIDTH-bit word.
- Sends a framed symbol sequence: preamble, data LSB first, then an idle gap.
- Drives the tone line and a symbol clock that feed the channel toward the FSK receiver.
- Mark (bit 1) is the fast tone and space (bit 0) is the slow tone, so the receiver's edge-count decision holds.

Parameters:
NREQ, 4, number of requesters
WIDTH, 12, data bits per frame
BIT_CYCLES, 32, clk cycles per symbol (even)
MARK_HALF, 2, half-period in cycles of mark tone (bit 1)
SPACE_HALF, 8, half-period in cycles of space tone (bit 0)
PRE_BITS, 4, preamble symbols, pattern 1,0,1,0,...
GAP_BITS, 2, silent symbols after data

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
req  in  NREQ  request per channel; held until gnt
data_in  in  NREQ*WIDTH  word of channel i at bits [i*WIDTH +: WIDTH]; stable while req[i] high
gnt  out  NREQ  one-hot one-cycle pulse: word taken
busy  out  1  high when state is not IDLE
tx_chan  out  clog2(NREQ)  index of channel being sent
fsk_out  out  1  modulated tone line
sym_clk  out  1  high for the first BIT_CYCLES/2 cycles of each symbol
frame_done  out  1  one-cycle pulse on the last cycle of GAP

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, port name reset.
- Reset values (also apply to reset mid-frame): state IDLE; gnt, busy, fsk_out, sym_clk and frame_done all 0; tx_chan 0; rr_ptr 0. Any captured word is discarded and no gnt is issued.
- States: IDLE -> SYNC -> DATA -> GAP -> IDLE.
- IDLE, arbitration: on an edge with any req[i]=1, select the first set index searching from rr_ptr upward with wrap.
  - On that edge: gnt[sel] registered to 1, word and tx_chan latched, rr_ptr = sel+1 mod NREQ, state SYNC.
  - gnt is high exactly one cycle, while state is already SYNC, so no double grant.
  - With no req, stay in IDLE; outputs hold 0.
- Symbol timing: sym_cnt counts 0..BIT_CYCLES-1 in SYNC, DATA and GAP, and resets to 0 on each state entry.
  - sym_clk = (sym_cnt < BIT_CYCLES/2) in those states; 0 in IDLE.
  - bit_idx counts symbols within a state.
  - SYNC ends after PRE_BITS symbols, DATA after WIDTH, GAP after GAP_BITS.
- Symbol value:
  - SYNC symbol n = 1 when n is even.
  - DATA symbol k = word[k], so word[0] is sent first.
  - GAP: fsk_out held 0, no tone.
- Tone generation:
  - At sym_cnt==0, tone_cnt is cleared and fsk_out set to 1.
  - fsk_out toggles whenever tone_cnt reaches HALF-1, then tone_cnt clears.
  - HALF is MARK_HALF for a 1 symbol and SPACE_HALF for a 0 symbol.
  - Per symbol this gives BIT_CYCLES/(2*MARK_HALF) rising edges for mark (8 at defaults) and BIT_CYCLES/(2*SPACE_HALF) for space (2 at defaults).
  - BIT_CYCLES must be a multiple of 2*SPACE_HALF and of 2*MARK_HALF; this is an elaboration check.
- Frame length: (PRE_BITS+WIDTH+GAP_BITS)*BIT_CYCLES cycles from the first SYNC cycle to re-entry into IDLE; 576 at defaults.
- Back-to-back: the first IDLE cycle after GAP may already sample req, so a minimum of one IDLE cycle separates frames.
- Request dropped before its grant edge: not granted, and rr_ptr is unchanged.
- req changes during SYNC, DATA or GAP are ignored; the latched word is used.
- busy = (state != IDLE). tx_chan holds its value until the next grant.

Test Plan:
- Reset asserted with req=4'b1111 -> gnt, busy, fsk_out and sym_clk stay 0; after release, gnt=4'b0001 on the first edge.
- req[2] only, data 12'hA5C -> gnt[2] pulse, tx_chan=2. Per-symbol rising-edge counts are:
  - preamble 8,2,8,2;
  - data LSB first 2,2,8,8, 8,2,8,2, 2,8,2,8;
  - 0 during GAP.
  - frame_done 576 cycles after the first SYNC cycle.
- req=4'b1111 held, rr_ptr 0 -> grant order 0,1,2,3,0; each pair of successive grants is 577 cycles apart.
- rr_ptr=3 with req=4'b0101 -> grant 0, then 2, then 0.
- Reset pulsed at data symbol 5 -> fsk_out goes to 0 immediately, state IDLE; the next request is granted normally from rr_ptr 0.
- req[1] pulsed for 1 cycle while busy -> no grant; with no other req, the block returns to IDLE and stays idle.

Source files
------------

// File: rtl/fsk_tx_scheduler.sv
// fsk_tx_scheduler: round-robin arbiter feeding one FSK modulator with framed preamble, LSB-first data and idle gap
module fsk_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 12,
    parameter int BIT_CYCLES = 32,
    parameter int MARK_HALF  = 2,
    parameter int SPACE_HALF = 8,
    parameter int PRE_BITS   = 4,
    parameter int GAP_BITS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   tx_chan,
    output logic                      fsk_out,
    output logic                      sym_clk,
    output logic                      frame_done
);
    localparam int CW   = $clog2(NREQ);
    localparam int SW   = $clog2(BIT_CYCLES);
    localparam int MAXB = WIDTH > PRE_BITS ? (WIDTH > GAP_BITS ? WIDTH : GAP_BITS)
                                           : (PRE_BITS > GAP_BITS ? PRE_BITS : GAP_BITS);
    localparam int BW   = $clog2(MAXB + 1);
    localparam int HMAX = MARK_HALF > SPACE_HALF ? MARK_HALF : SPACE_HALF;
    localparam int TW   = $clog2(HMAX + 1);

    if (BIT_CYCLES % (2*MARK_HALF) != 0 || BIT_CYCLES % (2*SPACE_HALF) != 0) begin : g_bad_timing
        $error("BIT_CYCLES must be a multiple of 2*MARK_HALF and 2*SPACE_HALF");
    end

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t           state, state_n;
    logic [SW-1:0]    sym_cnt, sym_cnt_n;
    logic [BW-1:0]    bit_idx, bit_idx_n;
    logic [TW-1:0]    tone_cnt, tone_cnt_n;
    logic [WIDTH-1:0] word, word_sel;
    logic [CW-1:0]    rr_ptr, sel, hi_sel, lo_sel;
    logic             hi_found, sym_last, bit_last, sym_bit, tone_hit, active_n, fsk_n;

    always_comb begin
        hi_found = 1'b0;
        hi_sel   = '0;
        lo_sel   = '0;
        word_sel = '0;
        // lowest requester at or above rr_ptr wins, otherwise wrap to the lowest overall
        for (int i = NREQ-1; i >= 0; i--) begin
            if (req[i] && CW'(i) >= rr_ptr) begin
                hi_found = 1'b1;
                hi_sel   = CW'(i);
            end
            if (req[i]) lo_sel = CW'(i);
        end
        sel = hi_found ? hi_sel : lo_sel;
        for (int i = 0; i < NREQ; i++)
            if (sel == CW'(i)) word_sel = data_in[i*WIDTH +: WIDTH];
        sym_last = sym_cnt == SW'(BIT_CYCLES-1);
        bit_last = state == SYNC ? bit_idx == BW'(PRE_BITS-1) :
                   state == DATA ? bit_idx == BW'(WIDTH-1) : bit_idx == BW'(GAP_BITS-1);
        sym_bit  = state == SYNC ? ~bit_idx[0] : |(word & (WIDTH'(1) << bit_idx));
        tone_hit = tone_cnt == (sym_bit ? TW'(MARK_HALF-1) : TW'(SPACE_HALF-1));
        state_n  = state;
        if (state == IDLE)
            state_n = |req ? SYNC : IDLE;
        else if (sym_last && bit_last)
            state_n = state == SYNC ? DATA : state == DATA ? GAP : IDLE;
        sym_cnt_n  = (state_n != state || sym_last || state == IDLE) ? '0 : sym_cnt + 1'b1;
        bit_idx_n  = state_n != state ? '0 : bit_idx + BW'(sym_last);
        active_n   = state_n == SYNC || state_n == DATA;
        // every symbol restarts its tone high; the gap and idle are silent
        fsk_n      = active_n && (sym_cnt_n == '0 || (tone_hit ? ~fsk_out : fsk_out));
        tone_cnt_n = (active_n && sym_cnt_n != '0 && !tone_hit) ? tone_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sym_cnt  <= '0;
            bit_idx  <= '0;
            tone_cnt <= '0;
            fsk_out  <= 1'b0;
            word     <= '0;
            tx_chan  <= '0;
            rr_ptr   <= '0;
            gnt      <= '0;
        end else begin
            state    <= state_n;
            sym_cnt  <= sym_cnt_n;
            bit_idx  <= bit_idx_n;
            tone_cnt <= tone_cnt_n;
            fsk_out  <= fsk_n;
            gnt      <= '0;
            if (state == IDLE && |req) begin
                gnt     <= NREQ'(1) << sel;
                word    <= word_sel;
                tx_chan <= sel;
                rr_ptr  <= sel == CW'(NREQ-1) ? '0 : sel + 1'b1;
            end
        end
    end

    assign busy       = state != IDLE;
    assign sym_clk    = busy && sym_cnt < SW'(BIT_CYCLES/2);
    assign frame_done = state == GAP && sym_last && bit_last;
endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// tb_fsk_tx_scheduler: directed and random requests checked each cycle against a frame-position model
module tb_fsk_tx_scheduler;
    localparam int NREQ = 4, WIDTH = 12, BC = 32, MH = 2, SH = 8, PRE = 4, GAP = 2;
    localparam int FRAME = (PRE + WIDTH + GAP) * BC;

    logic                  clk = 1'b0, reset = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] data_in = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy, fsk_out, sym_clk, frame_done;
    logic [1:0]            tx_chan;

    int n_vec = 0, n_bad = 0, cyc = 0;
    int exp_cnt[18] = '{8, 2, 8, 2, 2, 2, 8, 8, 8, 2, 8, 2, 2, 8, 2, 8, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsk_tx_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt), .busy(busy),
        .tx_chan(tx_chan), .fsk_out(fsk_out), .sym_clk(sym_clk), .frame_done(frame_done)
    );

    // model: a frame is just a position counter; outputs follow from position arithmetic
    logic             m_busy;
    int               m_pos, m_chan, m_ptr;
    logic [WIDTH-1:0] m_word;
    logic [NREQ-1:0]  m_gnt;

    function automatic int pick(logic [NREQ-1:0] r, int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_pos <= 0; m_chan <= 0; m_ptr <= 0; m_word <= '0; m_gnt <= '0;
        end else begin
            m_gnt <= '0;
            if (!m_busy) begin
                if (req != '0) begin
                    m_gnt  <= NREQ'(1) << pick(req, m_ptr);
                    m_word <= data_in[pick(req, m_ptr)*WIDTH +: WIDTH];
                    m_chan <= pick(req, m_ptr);
                    m_ptr  <= (pick(req, m_ptr) + 1) % NREQ;
                    m_busy <= 1'b1;
                    m_pos  <= 0;
                end
            end else if (m_pos == FRAME - 1) begin
                m_busy <= 1'b0;
                m_pos  <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int sym, t;
        logic bitv;
        logic [9:0] exp_v, act_v;
        sym  = m_pos / BC;
        t    = m_pos % BC;
        bitv = sym < PRE ? (sym % 2 == 0) : (sym < PRE + WIDTH ? m_word[sym - PRE] : 1'b0);
        exp_v = {m_gnt, m_busy, 2'(m_chan),
                 m_busy && sym < PRE + WIDTH && ((t / (bitv ? MH : SH)) % 2 == 0),
                 m_busy && t < BC/2, m_busy && m_pos == FRAME - 1};
        act_v = {gnt, busy, tx_chan, fsk_out, sym_clk, frame_done};
        n_vec++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_check cyc=%0d got gnt/busy/chan/fsk/sclk/done=%b want %b", cyc, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output int idx, output int stamp);
        idx = -1;
        stamp = -1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                for (int j = 0; j < NREQ; j++) if (gnt[j]) idx = j;
                stamp = cyc;
                return;
            end
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1200 && busy; i++) @(negedge clk);
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int idx, st, c, fd_c, g;
        int stamps[5], order[5];
        int cnt[18];
        logic prev;
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        int wr_exp[3] = '{0, 2, 0};
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = 12'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fsk", fsk_out, 0);
        chk("rst_symclk", sym_clk, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("first_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle();

        data_in[2*WIDTH +: WIDTH] = 12'hA5C;
        req = 4'b0100;
        wait_gnt(idx, st);
        req = '0;
        chk("a5c_gnt", idx, 2);
        chk("a5c_chan", tx_chan, 2);
        for (int i = 0; i < 18; i++) cnt[i] = 0;
        c = 0; prev = 1'b0; fd_c = -1;
        while (busy && c < 700) begin
            if (fsk_out && !prev) cnt[c / BC]++;
            prev = fsk_out;
            if (frame_done) fd_c = c;
            @(negedge clk);
            c++;
        end
        chk("frame_len", c, 576);
        chk("frame_done_at", fd_c, 575);
        for (int i = 0; i < 18; i++) chk($sformatf("edges_sym%0d", i), cnt[i], exp_cnt[i]);

        pulse_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(order[i], stamps[i]);
            chk($sformatf("rr_order%0d", i), order[i], rr_exp[i]);
            if (i > 0) chk($sformatf("rr_spacing%0d", i), stamps[i] - stamps[i-1], 577);
        end
        req = '0;
        wait_idle();

        pulse_reset();
        req = 4'b0100;
        wait_gnt(idx, st);
        req = '0;
        chk("ptr3_setup", idx, 2);
        wait_idle();
        req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            wait_gnt(idx, st);
            chk($sformatf("wrap_order%0d", i), idx, wr_exp[i]);
        end
        req = '0;
        wait_idle();

        data_in[0 +: WIDTH] = 12'hFFF;
        req = 4'b0001;
        wait_gnt(idx, st);
        req = '0;
        repeat ((PRE + 5) * BC) @(posedge clk);
        #1;
        chk("fsk_sym5_high", fsk_out, 1);
        reset = 1'b0;
        #1;
        chk("midrst_fsk", fsk_out, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        req = 4'b1010;
        wait_gnt(idx, st);
        req = '0;
        chk("post_rst_gnt", idx, 1);
        repeat (50) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        wait_idle();
        g = 0;
        repeat (100) begin
            @(negedge clk);
            if (gnt != '0 || busy) g++;
        end
        chk("idle_after_pulse", g, 0);

        repeat (200) begin
            for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = 12'($urandom);
            req = 4'($urandom);
            if ($urandom_range(0, 24) == 0) pulse_reset();
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        req = '0;
        wait_idle();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
